uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

- Receive-side command decoder for the serial display/host link.
- Consumes bytes from the UART byte receiver and parses ASCII command frames of the form `SET(c,dddd);` and `GET(c);`.
- On a valid frame, presents the channel and the decoded BCD value (thousand/hundreds/tens/ones) to the application logic, e.g. alarm thresholds or setpoints.
- It is the inbound counterpart of the status-message transmit sequencer that drives the same link.

## Interface
Parameters:
- `TO`, 200_000: inter-byte timeout in clk cycles, used mid-frame only.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `rx_done` in 1: one-cycle strobe; `rx_data` is valid in this cycle.
- `rx_data` in 8: received byte.
- `cmd_valid` out 1: one-cycle pulse on an accepted frame.
- `cmd_set` out 1: 1 = SET, 0 = GET; held until the next `cmd_valid`.
- `cmd_ch` out 4: channel digit 0–9; held.
- `thousand` out 4: BCD digit; held; updated only by SET.
- `hundreds` out 4: BCD digit; held; updated only by SET.
- `tens` out 4: BCD digit; held; updated only by SET.
- `ones` out 4: BCD digit; held; updated only by SET.
- `frm_err` out 1: one-cycle pulse on frame abort.

## Operation
- All state advances only on `rx_done`, except the timeout.
- States:
  - IDLE: 'S' → K1 with type=SET; 'G' → K1 with type=GET; any other byte ignored, no error (covers 0x0A/0x0D line endings).
  - K1: expect 'E' → K2.
  - K2: expect 'T' → LP.
  - LP: expect '(' → CH.
  - CH: '0'–'9' → latch channel = byte−48 → SEP.
  - SEP: SET expects ',' → DIG with digit count cleared; GET expects ')' → SC.
  - DIG:
    - '0'–'9' while count<4 → shift the shadow value left one BCD digit, insert byte−48 at ones, count+1.
    - ')' with count≥1 → SC.
    - A 5th digit, ')' with count=0, or any other byte → error.
  - SC: ';' → commit and pulse `cmd_valid` → IDLE.
- Any unexpected byte outside IDLE: pulse `frm_err`, go to IDLE.
  - The offending byte is discarded, not re-parsed, even if it is 'S' or 'G'.
- Value assembly:
  - A 4-digit shadow register is cleared on entry to DIG.
  - Digits are right-aligned: "37" → 0,0,3,7.
  - The shadow is copied to `thousand`..`ones` only on commit of a SET.
  - GET and aborted frames leave the digit outputs unchanged.
- `cmd_set` and `cmd_ch` update only on commit.
- Digit subtraction is 8-bit (`rx_data` − 8'd48); the low 4 bits are taken after the range check.

## Timing
- Reset values: all outputs 0; state IDLE; shadow 0; count 0; timeout counter 0.
- Latency: `cmd_valid` and the updated data outputs are visible in the cycle after the `rx_done` that carries ';' (registered).
- `frm_err` also asserts in the cycle after the offending `rx_done`.
- `cmd_valid` and `frm_err` are never high together.
- Back-to-back `rx_done` on consecutive cycles must be accepted with no lost bytes.
- Timeout (when compiled in):
  - The counter is cleared on every `rx_done` and held at 0 in IDLE.
  - It increments otherwise.
  - Reaching TO−1 → `frm_err` pulse next cycle, state IDLE, counter 0.
  - If `rx_done` occurs in the same cycle the counter reaches TO−1, the byte wins: it is parsed and the counter is cleared.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs 0; the partial frame is lost and no `frm_err` is raised.

## Configuration
- `CMD_TIMEOUT_EN`
  - Defined: the inter-byte timeout described above is active.
  - Undefined: the timeout counter is removed and `TO` is unused; a partial frame waits indefinitely, and only a bad byte or reset returns the parser to IDLE.

## Test plan
- "SET(2,37);\n" at back-to-back strobes → one `cmd_valid`; `cmd_set`=1, `cmd_ch`=2, digits 0,0,3,7; no `frm_err`.
- "SET(5,1234);" then "GET(9);" → first: digits 1,2,3,4. Second: `cmd_set`=0, `cmd_ch`=9, digits remain 1,2,3,4.
- "SET(1,12345);" → `frm_err` one cycle after '5'; ')' and ';' ignored in IDLE; digits unchanged.
- "SET(1,);" and "SXT(" → `frm_err` after ')' and after 'X' respectively; the following "GET(3);" parses correctly.
- With `CMD_TIMEOUT_EN` and `TO`=16: "SET(4," then 20 idle cycles → `frm_err` 16 cycles after the ',' strobe, state IDLE; a byte arriving exactly on the TO−1 cycle suppresses the error.
- `rst_n`=0 for one cycle after "SET(7,8" → all outputs 0; "8);" afterwards produces no `cmd_valid` and no `frm_err`.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII SET(c,dddd); / GET(c); command frame decoder
//
// Optional feature macro: CMD_TIMEOUT_EN (inter-byte timeout of TO clk cycles mid-frame).
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   rx_done   one-cycle strobe, rx_data valid
//   rx_data   received byte
//   cmd_valid one-cycle pulse on an accepted frame
//   cmd_set   1 = SET, 0 = GET (held)
//   cmd_ch    channel digit (held)
//   thousand, hundreds, tens, ones  BCD value of the last committed SET (held)
//   frm_err   one-cycle pulse on frame abort
module uart_cmd_parser #(
  parameter int TO = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       cmd_valid,
  output logic       cmd_set,
  output logic [3:0] cmd_ch,
  output logic [3:0] thousand,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       frm_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_K1, S_K2, S_LP, S_CH, S_SEP, S_DIG, S_SC
  } state_t;

  state_t      state, state_d;
  logic        type_set, type_set_d;
  logic [3:0]  ch_q, ch_d;
  logic [15:0] shadow, shadow_d;
  logic [2:0]  count, count_d;
  logic        commit, abort;
  logic        timeout;
  logic        is_digit;
  logic [3:0]  digit;

  // Range check on the raw byte; the 8-bit difference is only narrowed
  // to a nibble once the byte is known to be '0'..'9'.
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign digit    = 4'(rx_data - 8'd48);

`ifdef CMD_TIMEOUT_EN
  localparam int CW = $clog2(TO + 1);
  logic [CW-1:0] tmr;

  // A strobe in the same cycle as the last count wins over the timeout.
  assign timeout = (state != S_IDLE) && (tmr == CW'(TO - 1)) && !rx_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (rx_done || (state == S_IDLE) || timeout) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + CW'(1);
    end
  end
`else
  // No counter in this build; the comparison is constant false and only
  // keeps TO referenced so the interface stays identical.
  assign timeout = (TO < 0);
`endif

  always_comb begin
    state_d    = state;
    type_set_d = type_set;
    ch_d       = ch_q;
    shadow_d   = shadow;
    count_d    = count;
    commit     = 1'b0;
    abort      = 1'b0;
    if (rx_done) begin
      case (state)
        S_IDLE: begin
          // Anything other than a frame start (line endings included) is ignored.
          if (rx_data == "S") begin
            state_d    = S_K1;
            type_set_d = 1'b1;
          end else if (rx_data == "G") begin
            state_d    = S_K1;
            type_set_d = 1'b0;
          end
        end
        S_K1: if (rx_data == "E") state_d = S_K2; else abort = 1'b1;
        S_K2: if (rx_data == "T") state_d = S_LP; else abort = 1'b1;
        S_LP: if (rx_data == "(") state_d = S_CH; else abort = 1'b1;
        S_CH: begin
          if (is_digit) begin
            ch_d    = digit;
            state_d = S_SEP;
          end else begin
            abort = 1'b1;
          end
        end
        S_SEP: begin
          if (type_set && (rx_data == ",")) begin
            state_d  = S_DIG;
            shadow_d = '0;
            count_d  = '0;
          end else if (!type_set && (rx_data == ")")) begin
            state_d = S_SC;
          end else begin
            abort = 1'b1;
          end
        end
        S_DIG: begin
          // Shift left one BCD digit so the value ends up right-aligned.
          if (is_digit && (count < 3'd4)) begin
            shadow_d = {shadow[11:0], digit};
            count_d  = count + 3'd1;
          end else if ((rx_data == ")") && (count != 3'd0)) begin
            state_d = S_SC;
          end else begin
            abort = 1'b1;
          end
        end
        S_SC: begin
          if (rx_data == ";") begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            abort = 1'b1;
          end
        end
        default: abort = 1'b1;
      endcase
      // The offending byte is dropped, never re-parsed as a frame start.
      if (abort) state_d = S_IDLE;
    end else if (timeout) begin
      abort   = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      type_set  <= 1'b0;
      ch_q      <= '0;
      shadow    <= '0;
      count     <= '0;
      cmd_valid <= 1'b0;
      frm_err   <= 1'b0;
      cmd_set   <= 1'b0;
      cmd_ch    <= '0;
      thousand  <= '0;
      hundreds  <= '0;
      tens      <= '0;
      ones      <= '0;
    end else begin
      state     <= state_d;
      type_set  <= type_set_d;
      ch_q      <= ch_d;
      shadow    <= shadow_d;
      count     <= count_d;
      cmd_valid <= commit;
      frm_err   <= abort;
      if (commit) begin
        cmd_set <= type_set;
        cmd_ch  <= ch_q;
        // GET leaves the held value untouched.
        if (type_set) begin
          {thousand, hundreds, tens, ones} <= shadow;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

  localparam int TO_T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cmd_valid, cmd_set, frm_err;
  logic [3:0] cmd_ch, thousand, hundreds, tens, ones;

  uart_cmd_parser #(.TO(TO_T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_set(cmd_set), .cmd_ch(cmd_ch),
    .thousand(thousand), .hundreds(hundreds), .tens(tens), .ones(ones),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  wire [22:0] obs = {cmd_valid, frm_err, cmd_set, cmd_ch, thousand, hundreds, tens, ones};

  // Reference model: the bytes of the frame in progress, judged against the
  // frame grammar as a whole; committed results are kept as plain integers.
  logic [7:0] q[$];
  int idle;
  bit exp_valid, exp_err, m_set;
  int m_ch;
  int m_dig[4];

  function automatic void model_reset();
    q.delete();
    idle = 0; exp_valid = 0; exp_err = 0; m_set = 0; m_ch = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endfunction

  function automatic logic [22:0] exp_vec();
    return {exp_valid, exp_err, m_set, 4'(m_ch), 4'(m_dig[0]), 4'(m_dig[1]),
            4'(m_dig[2]), 4'(m_dig[3])};
  endfunction

  // 0 = not a prefix of any legal frame, 1 = legal prefix, 2 = complete frame
  function automatic int frame_status();
    int n = q.size();
    int d = 0;
    bit closed = 0;
    bit is_set = (q[0] == "S");
    bit ok;
    logic [7:0] c;
    bit dig;
    for (int i = 1; i < n; i++) begin
      c = q[i];
      dig = (c >= "0") && (c <= "9");
      if (i == 1) ok = (c == "E");
      else if (i == 2) ok = (c == "T");
      else if (i == 3) ok = (c == "(");
      else if (i == 4) ok = dig;
      else if (!is_set) ok = (i == 5) ? (c == ")") : ((i == 6) && (c == ";"));
      else if (i == 5) ok = (c == ",");
      else if (!closed) begin
        if (dig) begin d++; ok = (d <= 4); end
        else if (c == ")") begin ok = (d >= 1); closed = 1; end
        else ok = 0;
      end else ok = (c == ";");
      if (!ok) return 0;
    end
    return (q[n-1] == ";") ? 2 : 1;
  endfunction

  function automatic void commit_frame();
    int val = 0;
    m_set = (q[0] == "S");
    m_ch = int'(q[4]) - 48;
    if (m_set) begin
      for (int i = 6; i < q.size() - 2; i++) val = val * 10 + (int'(q[i]) - 48);
      m_dig[0] = val / 1000;
      m_dig[1] = (val / 100) % 10;
      m_dig[2] = (val / 10) % 10;
      m_dig[3] = val % 10;
    end
  endfunction

  function automatic void model_step(input logic [7:0] b, input bit strobe);
    int st;
    exp_valid = 0;
    exp_err = 0;
    if (strobe) begin
      idle = 0;
      if (q.size() == 0) begin
        if (b == "S" || b == "G") q.push_back(b);
      end else begin
        q.push_back(b);
        st = frame_status();
        if (st == 0) begin exp_err = 1; q.delete(); end
        else if (st == 2) begin exp_valid = 1; commit_frame(); q.delete(); end
      end
    end else if (q.size() != 0) begin
`ifdef CMD_TIMEOUT_EN
      idle++;
      if (idle == TO_T) begin exp_err = 1; q.delete(); idle = 0; end
`endif
    end
  endfunction

  // One clock: optional byte strobe, then model update; sampling is #1 after the edge.
  task automatic step(input logic [7:0] b, input bit strobe);
    @(negedge clk);
    rx_done = strobe;
    rx_data = strobe ? b : 8'($urandom);
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    model_step(b, strobe);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_done = 1'b1;
    rx_data = "S";
    repeat (2) @(posedge clk);
    #1;
    rx_done = 1'b0;
    model_reset();
    checks++;
    if (obs !== 23'h0) begin errors++; $display("FAIL reset: got %h want %h", obs, 23'h0); end
    rst_n = 1'b1;
    step(8'h00, 0);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_set_basic();
    string s = "SET(2,37);\n";
    int nv = 0, ne = 0;
    for (int i = 0; i < s.len(); i++) begin
      step(s[i], 1);
      nv += int'(cmd_valid); ne += int'(frm_err);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL set_basic byte %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (nv != 1 || ne != 0) begin errors++; $display("FAIL set_basic pulses: got valid=%0d err=%0d want 1 0", nv, ne); end
    checks++;
    if ({cmd_set, cmd_ch, thousand, hundreds, tens, ones} !== {1'b1, 20'h20037}) begin
      errors++; $display("FAIL set_basic data: got %h want %h", {cmd_set, cmd_ch, thousand, hundreds, tens, ones}, {1'b1, 20'h20037});
    end
  endtask

  task automatic test_set_get();
    string s = "SET(5,1234);GET(9);";
    for (int i = 0; i < s.len(); i++) begin
      step(s[i], 1);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL set_get byte %0d: got %h want %h", i, obs, exp_vec()); end
      if (i == 11) begin
        checks++;
        if ({cmd_valid, cmd_set, cmd_ch, thousand, hundreds, tens, ones} !== {2'b11, 20'h51234}) begin
          errors++; $display("FAIL set_get first: got %h want %h", {cmd_valid, cmd_set, cmd_ch, thousand, hundreds, tens, ones}, {2'b11, 20'h51234});
        end
      end
    end
    checks++;
    if ({cmd_valid, cmd_set, cmd_ch, thousand, hundreds, tens, ones} !== {2'b10, 20'h91234}) begin
      errors++; $display("FAIL set_get second: got %h want %h", {cmd_valid, cmd_set, cmd_ch, thousand, hundreds, tens, ones}, {2'b10, 20'h91234});
    end
  endtask

  task automatic test_overflow();
    string s = "SET(1,12345);";
    int err_at = -1, nv = 0;
    for (int i = 0; i < s.len(); i++) begin
      step(s[i], 1);
      if (frm_err && err_at < 0) err_at = i;
      nv += int'(cmd_valid);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL overflow byte %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (err_at != 10 || nv != 0) begin errors++; $display("FAIL overflow err_at: got %0d valid=%0d want 10 0", err_at, nv); end
    checks++;
    if ({thousand, hundreds, tens, ones} !== 16'h1234) begin
      errors++; $display("FAIL overflow digits: got %h want %h", {thousand, hundreds, tens, ones}, 16'h1234);
    end
  endtask

  task automatic test_bad_frames();
    string s = "SET(1,);SXT(GET(3);";
    int err_idx[$];
    int nv = 0;
    for (int i = 0; i < s.len(); i++) begin
      step(s[i], 1);
      if (frm_err) err_idx.push_back(i);
      nv += int'(cmd_valid);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL bad_frames byte %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (err_idx.size() != 2 || err_idx[0] != 6 || err_idx[1] != 9 || nv != 1) begin
      errors++; $display("FAIL bad_frames errs: got count=%0d valid=%0d want errors at 6,9 and one valid", err_idx.size(), nv);
    end
    checks++;
    if ({cmd_set, cmd_ch, thousand, hundreds, tens, ones} !== {1'b0, 20'h31234}) begin
      errors++; $display("FAIL bad_frames get: got %h want %h", {cmd_set, cmd_ch, thousand, hundreds, tens, ones}, {1'b0, 20'h31234});
    end
  endtask

  task automatic test_timeout();
    string s1 = "SET(4,";
    string s2 = "1);";
    int err_at = -1, nv = 0, ne = 0, want_at, want_nv;
`ifdef CMD_TIMEOUT_EN
    want_at = TO_T; want_nv = 0;
`else
    want_at = -1; want_nv = 1;
`endif
    for (int i = 0; i < s1.len(); i++) step(s1[i], 1);
    for (int k = 1; k <= 20; k++) begin
      step(8'h00, 0);
      if (frm_err && err_at < 0) err_at = k;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL timeout idle %0d: got %h want %h", k, obs, exp_vec()); end
    end
    checks++;
    if (err_at != want_at) begin errors++; $display("FAIL timeout err_at: got %0d want %0d", err_at, want_at); end
    for (int i = 0; i < s2.len(); i++) begin
      step(s2[i], 1);
      nv += int'(cmd_valid);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL timeout tail %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (nv != want_nv) begin errors++; $display("FAIL timeout tail_valid: got %0d want %0d", nv, want_nv); end
    nv = 0;
    for (int i = 0; i < s1.len(); i++) step(s1[i], 1);
    for (int k = 1; k < TO_T; k++) begin
      step(8'h00, 0);
      ne += int'(frm_err);
    end
    for (int i = 0; i < s2.len(); i++) begin
      step(s2[i], 1);
      nv += int'(cmd_valid); ne += int'(frm_err);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL timeout edge %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (nv != 1 || ne != 0 || {thousand, hundreds, tens, ones} !== 16'h0001) begin
      errors++; $display("FAIL timeout edge_byte: got valid=%0d err=%0d digits=%h want 1 0 0001", nv, ne, {thousand, hundreds, tens, ones});
    end
  endtask

  task automatic test_mid_reset();
    string s1 = "SET(7,8";
    string s2 = "8);";
    int nv = 0, ne = 0;
    for (int i = 0; i < s1.len(); i++) step(s1[i], 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (obs !== 23'h0) begin errors++; $display("FAIL mid_reset outputs: got %h want %h", obs, 23'h0); end
    for (int i = 0; i < s2.len(); i++) begin
      step(s2[i], 1);
      nv += int'(cmd_valid); ne += int'(frm_err);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL mid_reset byte %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++;
    if (nv != 0 || ne != 0) begin errors++; $display("FAIL mid_reset pulses: got valid=%0d err=%0d want 0 0", nv, ne); end
  endtask

  task automatic test_random();
    string junk = "\r\nxz;)0(,";
    string bad = "SETG(),;0159x";
    logic [7:0] f[$];
    int nd, pos;
    for (int n = 0; n < 80; n++) begin
      f.delete();
      case ($urandom_range(0, 4))
        0: for (int j = 0; j < int'($urandom_range(1, 3)); j++) f.push_back(junk[$urandom_range(0, junk.len() - 1)]);
        3: begin
          f.push_back("G"); f.push_back("E"); f.push_back("T"); f.push_back("(");
          f.push_back(8'(48 + $urandom_range(0, 9))); f.push_back(")"); f.push_back(";");
        end
        default: begin
          f.push_back("S"); f.push_back("E"); f.push_back("T"); f.push_back("(");
          f.push_back(8'(48 + $urandom_range(0, 9))); f.push_back(",");
          nd = $urandom_range(1, 4);
          for (int j = 0; j < nd; j++) f.push_back(8'(48 + $urandom_range(0, 9)));
          f.push_back(")"); f.push_back(";");
        end
      endcase
      if (f.size() > 3 && $urandom_range(0, 3) == 0) begin
        pos = $urandom_range(1, f.size() - 1);
        f[pos] = bad[$urandom_range(0, bad.len() - 1)];
      end
      foreach (f[j]) begin
        repeat ($urandom_range(0, 2)) begin
          step(8'h00, 0);
          checks++;
          if (obs !== exp_vec()) begin errors++; $display("FAIL random gap frame %0d: got %h want %h", n, obs, exp_vec()); end
        end
        step(f[j], 1);
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL random frame %0d byte %0d: got %h want %h", n, j, obs, exp_vec()); end
        checks++;
        if (cmd_valid && frm_err) begin errors++; $display("FAIL random exclusive: got both high want at most one"); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_set_basic();
    test_set_get();
    test_overflow();
    test_bad_frames();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
